pkt_fifo_sync: RTL

Single-clock, parametrised packet FIFO for the custom router: the successor to the dual-clock packet FIFO, generalised in packet slot count and length, and adding per-packet validation (size bound, optional checksum).
- Write side: the source writes packet bytes by offset into a staging slot, then commits the whole packet with winc.
- Read side: the consumer reads any byte of the head packet by offset and pops it with rinc.
- Adds occupancy and drop counters.

---
 rtl/pkt_fifo_pkg.sv | 16 +
 rtl/pkt_fifo_mem.sv | 37 +++
 rtl/pkt_fifo_sync.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pkt_fifo_pkg.sv
// Shared packet layout offsets and write-side FSM states for the packet FIFO.
package pkt_fifo_pkg;

    localparam int unsigned SRC_OFS   = 0;
    localparam int unsigned DST_OFS   = 1;
    localparam int unsigned SIZE_OFS  = 2;
    localparam int unsigned DATA_OFS  = 3;
    localparam int unsigned HDR_BYTES = 3;

    typedef enum logic [1:0] {
        W_FILL,
        W_CHECK,
        W_COMMIT
    } wstate_e;

endpackage

// File: rtl/pkt_fifo_mem.sv
// DEPTH x WIDTH byte array: one write port, a head-byte read port and a
// second read port used for the size lookup and checksum walk.
module pkt_fifo_mem
    import pkt_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned WIDTH     = 11,
    parameter int unsigned UWIDTH    = 8,
    parameter int unsigned PTR_SZ    = 2,
    parameter int unsigned PTR_IN_SZ = 4
) (
    input  logic                 clk1,
    input  logic                 we,
    input  logic [PTR_SZ-1:0]    wslot,
    input  logic [PTR_IN_SZ-1:0] wofs,
    input  logic [UWIDTH-1:0]    wdata,
    input  logic [PTR_SZ-1:0]    hslot,
    input  logic [PTR_IN_SZ-1:0] hofs,
    output logic [UWIDTH-1:0]    hbyte,
    input  logic [PTR_SZ-1:0]    cslot,
    input  logic [PTR_IN_SZ-1:0] cofs,
    output logic [UWIDTH-1:0]    cbyte
);

    logic [UWIDTH-1:0] mem [DEPTH][WIDTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk1) begin
        if (we) begin
            mem[wslot][wofs] <= wdata;
        end
    end

    assign hbyte = mem[hslot][hofs];
    assign cbyte = mem[cslot][cofs];

endmodule

// File: rtl/pkt_fifo_sync.sv
// Single-clock packet FIFO with per-packet size validation and drop counting.
// Optional checksum validation is enabled by defining CRC_CHECK_EN.
module pkt_fifo_sync
    import pkt_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned WIDTH     = 11,
    parameter int unsigned UWIDTH    = 8,
    parameter int unsigned PTR_SZ    = 2,
    parameter int unsigned PTR_IN_SZ = 4,
    parameter int unsigned CNT_SZ    = 8
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 winc,
    input  logic [PTR_IN_SZ-1:0] waddr_in,
    input  logic [UWIDTH-1:0]    wdata,
    output logic                 wready,
    output logic                 wfull,
    output logic                 wovf,
    input  logic                 rinc,
    input  logic [PTR_IN_SZ-1:0] raddr_in,
    output logic [UWIDTH-1:0]    rdata,
    output logic                 rempty,
    output logic [PTR_SZ:0]      count,
    output logic [CNT_SZ-1:0]    drop_cnt
);

    localparam int unsigned CW       = PTR_SZ + 1;
    localparam int unsigned MAX_SIZE = WIDTH - HDR_BYTES - 1;

    wstate_e               state, state_n;
    logic [PTR_SZ-1:0]     wptr, rptr;
    logic                  commit, drop, ovf, pop, we, size_big;
    logic [PTR_IN_SZ-1:0]  cofs;
    logic [UWIDTH-1:0]     hbyte, cbyte;

    assign wready   = (state == W_FILL);
    assign wfull    = (count == CW'(DEPTH));
    assign rempty   = (count == '0);
    assign pop      = rinc && !rempty;
    assign we       = wready && (32'(waddr_in) < WIDTH);
    assign size_big = 32'(cbyte) > MAX_SIZE;

    pkt_fifo_mem #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .UWIDTH   (UWIDTH),
        .PTR_SZ   (PTR_SZ),
        .PTR_IN_SZ(PTR_IN_SZ)
    ) u_mem (
        .clk1 (clk1),
        .we   (we),
        .wslot(wptr),
        .wofs (waddr_in),
        .wdata(wdata),
        .hslot(rptr),
        .hofs (raddr_in),
        .hbyte(hbyte),
        .cslot(wptr),
        .cofs (cofs),
        .cbyte(cbyte)
    );

`ifdef CRC_CHECK_EN
    logic [PTR_IN_SZ-1:0] idx;
    logic [UWIDTH-1:0]    acc, size_q;
    logic                 last;

    assign last = (32'(idx) == 32'(size_q) + 32'(HDR_BYTES - 1));

    // size_q tracks the staged size byte while filling, so it holds the
    // validated size on entry to W_CHECK.
    always_ff @(posedge clk1) begin
        if (rst) begin
            idx    <= PTR_IN_SZ'(SRC_OFS);
            acc    <= '0;
            size_q <= '0;
        end else if (state == W_FILL) begin
            idx    <= PTR_IN_SZ'(SRC_OFS);
            acc    <= '0;
            size_q <= cbyte;
        end else if (state == W_CHECK) begin
            idx    <= idx + PTR_IN_SZ'(1);
            acc    <= acc ^ cbyte;
        end
    end

    always_comb begin
        cofs = PTR_IN_SZ'(SIZE_OFS);
        case (state)
            W_CHECK:  cofs = idx;
            W_COMMIT: cofs = PTR_IN_SZ'(32'(size_q) + DATA_OFS);
            default:  cofs = PTR_IN_SZ'(SIZE_OFS);
        endcase
    end
`else
    assign cofs = PTR_IN_SZ'(SIZE_OFS);
`endif

    always_comb begin
        state_n = state;
        commit  = 1'b0;
        drop    = 1'b0;
        ovf     = 1'b0;
        case (state)
            W_FILL: begin
                if (winc) begin
                    if (wfull) begin
                        ovf = 1'b1;
                    end else if (size_big) begin
                        drop = 1'b1;
                    end else begin
`ifdef CRC_CHECK_EN
                        state_n = W_CHECK;
`else
                        commit = 1'b1;
`endif
                    end
                end
            end
`ifdef CRC_CHECK_EN
            W_CHECK: begin
                if (last) begin
                    state_n = W_COMMIT;
                end
            end
            W_COMMIT: begin
                if (cbyte == acc) begin
                    commit = 1'b1;
                end else begin
                    drop = 1'b1;
                end
                state_n = W_FILL;
            end
`endif
            default: state_n = W_FILL;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state <= W_FILL;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            drop_cnt <= '0;
            wovf     <= 1'b0;
            rdata    <= '0;
        end else begin
            wovf  <= ovf;
            count <= count + CW'(commit) - CW'(pop);
            if (commit) begin
                wptr <= (wptr == PTR_SZ'(DEPTH - 1)) ? '0 : wptr + PTR_SZ'(1);
            end
            if (pop) begin
                rptr <= (rptr == PTR_SZ'(DEPTH - 1)) ? '0 : rptr + PTR_SZ'(1);
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_SZ'(1);
            end
            if (rempty || (32'(raddr_in) >= WIDTH)) begin
                rdata <= '0;
            end else begin
                rdata <= hbyte;
            end
        end
    end

endmodule
